// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - pushbutton synchronizer and debouncer with press/release strobes
// Optional rejected-transition counter enabled by KEY_DEBOUNCE_GLITCH_STATS_EN.
module key_debounce #(
  parameter int STABLE_CYCLES = 500000,
  parameter int CNT_W         = 20,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_raw,
  output logic        key_level,
  output logic        press_pulse,
  output logic        release_pulse
`ifdef KEY_DEBOUNCE_GLITCH_STATS_EN
  ,
  output logic [15:0] glitch_cnt
`endif
);

  typedef enum logic [1:0] {REL, CHK_P, PRS, CHK_R} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic             RAW_IDLE = (ACTIVE_LOW != 0);

  logic             s1, s2, k;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             level_nxt, press_nxt, release_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= RAW_IDLE;
      s2 <= RAW_IDLE;
    end else begin
      s1 <= key_raw;
      s2 <= s1;
    end
  end

  assign k = s2 ^ RAW_IDLE;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= REL;
      cnt           <= '0;
      key_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      key_level     <= level_nxt;
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    level_nxt   = key_level;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    case (state)
      REL: begin
        if (k) begin
          state_nxt = CHK_P;
          cnt_nxt   = '0;
        end
      end
      CHK_P: begin
        if (!k) begin
          state_nxt = REL;
        end else if (cnt == CNT_LAST) begin
          state_nxt = PRS;
          level_nxt = 1'b1;
          press_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      PRS: begin
        if (!k) begin
          state_nxt = CHK_R;
          cnt_nxt   = '0;
        end
      end
      CHK_R: begin
        if (k) begin
          state_nxt = PRS;
        end else if (cnt == CNT_LAST) begin
          state_nxt   = REL;
          level_nxt   = 1'b0;
          release_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = REL;
    endcase
  end

`ifdef KEY_DEBOUNCE_GLITCH_STATS_EN
  // A glitch is any reversal that drops a check state back to its stable state.
  logic glitch;
  assign glitch = ((state == CHK_P) && !k) || ((state == CHK_R) && k);

  always_ff @(posedge clk) begin
    if (reset) begin
      glitch_cnt <= '0;
    end else if (glitch && (glitch_cnt != 16'hFFFF)) begin
      glitch_cnt <= glitch_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - self-checking bench for key_debounce (STABLE_CYCLES=8, ACTIVE_LOW=1)
module tb_key_debounce;

  localparam int S = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_raw;
  logic        key_level;
  logic        press_pulse;
  logic        release_pulse;
`ifdef KEY_DEBOUNCE_GLITCH_STATS_EN
  logic [15:0] glitch_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // Reference: a raw two-sample delay, then a run-length rule: the level flips once
  // S+1 consecutive samples disagree with it; an interrupted run counts as a glitch.
  logic        m_s1, m_s2, m_level, m_press, m_release;
  int          m_run;
  logic [15:0] m_glitch;

  key_debounce #(.STABLE_CYCLES(S), .CNT_W(4), .ACTIVE_LOW(1)) dut (
    .clk(clk),
    .reset(reset),
    .key_raw(key_raw),
    .key_level(key_level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse)
`ifdef KEY_DEBOUNCE_GLITCH_STATS_EN
    ,
    .glitch_cnt(glitch_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic r_raw, r_rst, k;
    r_raw = key_raw;
    r_rst = reset;
    @(posedge clk);
    if (r_rst) begin
      m_s1 = 1'b1; m_s2 = 1'b1; m_level = 1'b0; m_run = 0;
      m_press = 1'b0; m_release = 1'b0; m_glitch = 16'd0;
    end else begin
      k = ~m_s2;
      m_s2 = m_s1;
      m_s1 = r_raw;
      m_press = 1'b0;
      m_release = 1'b0;
      if (k != m_level) begin
        m_run++;
        if (m_run == S + 1) begin
          m_level = k;
          m_run = 0;
          if (k) m_press = 1'b1;
          else   m_release = 1'b1;
        end
      end else begin
        if (m_run > 0 && m_glitch != 16'hFFFF) m_glitch++;
        m_run = 0;
      end
    end
    #1;
    check("model_level", 16'(key_level), 16'(m_level));
    check("model_press", 16'(press_pulse), 16'(m_press));
    check("model_release", 16'(release_pulse), 16'(m_release));
    check("pulse_exclusive", 16'(press_pulse & release_pulse), 16'd0);
`ifdef KEY_DEBOUNCE_GLITCH_STATS_EN
    check("model_glitch", glitch_cnt, m_glitch);
`endif
  endtask

  initial begin
    logic [15:0] g0;
    int len;
    reset = 1'b1;
    key_raw = 1'b1;
    m_s1 = 1'b1; m_s2 = 1'b1; m_level = 1'b0; m_run = 0;
    m_press = 1'b0; m_release = 1'b0; m_glitch = 16'd0;
    g0 = 16'd0;
    tick();
    tick();
    check("rst_level", 16'(key_level), 16'd0);
    check("rst_press", 16'(press_pulse), 16'd0);
    check("rst_release", 16'(release_pulse), 16'd0);

    reset = 1'b0;
    repeat (20) tick();
    check("idle_level", 16'(key_level), 16'd0);

    // Press: raw first sampled low at relative edge 1, accepted at edge 1+2+S.
    key_raw = 1'b0;
    for (int i = 1; i <= S + 4; i++) begin
      tick();
      check("press_timing", 16'(press_pulse), 16'(i == S + 3));
      check("press_level", 16'(key_level), 16'(i >= S + 3));
    end
    repeat (10) tick();

    // Short release bounce while held.
`ifdef KEY_DEBOUNCE_GLITCH_STATS_EN
    g0 = glitch_cnt;
`endif
    key_raw = 1'b1;
    repeat (3) tick();
    key_raw = 1'b0;
    repeat (20) tick();
    check("bounce_level", 16'(key_level), 16'd1);
`ifdef KEY_DEBOUNCE_GLITCH_STATS_EN
    check("bounce_glitch", glitch_cnt - g0, 16'd1);
`endif

    key_raw = 1'b1;
    repeat (20) tick();
    check("release_level", 16'(key_level), 16'd0);

    // Five short press bursts never qualify.
`ifdef KEY_DEBOUNCE_GLITCH_STATS_EN
    g0 = glitch_cnt;
`endif
    for (int b = 0; b < 5; b++) begin
      key_raw = 1'b0;
      repeat (5) tick();
      key_raw = 1'b1;
      repeat (4) tick();
    end
    repeat (6) tick();
    check("burst_level", 16'(key_level), 16'd0);
`ifdef KEY_DEBOUNCE_GLITCH_STATS_EN
    check("burst_glitch", glitch_cnt - g0, 16'd5);
`endif

    // Reset in the middle of press qualification, key still held.
    key_raw = 1'b0;
    repeat (7) tick();
    reset = 1'b1;
    tick();
    check("midrst_press", 16'(press_pulse), 16'd0);
    check("midrst_level", 16'(key_level), 16'd0);
    reset = 1'b0;
    for (int i = 1; i <= S + 4; i++) begin
      tick();
      check("postrst_press", 16'(press_pulse), 16'(i == S + 3));
    end
    key_raw = 1'b1;
    repeat (20) tick();

    // Randomized runs of mixed lengths with occasional resets.
    for (int r = 0; r < 150; r++) begin
      key_raw = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 14));
      reset = ($urandom_range(0, 29) == 0);
      tick();
      reset = 1'b0;
      repeat (len - 1) tick();
    end

`ifdef KEY_DEBOUNCE_GLITCH_STATS_EN
    // Alternating raw produces one glitch per two cycles; drive well past saturation.
    for (int g = 0; g < 70000; g++) begin
      key_raw = 1'b0;
      tick();
      key_raw = 1'b1;
      tick();
    end
    repeat (4) tick();
    check("glitch_sat", glitch_cnt, 16'hFFFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
